// File: rtl/regfile_stack_param.sv
// ID-stage register file with a hardware call stack that owns the stack-pointer register.
// Define REGFILE_BYPASS_EN to forward same-cycle writes (RegWrite / PC_Store) onto the read ports.
module regfile_stack_param #(
   parameter int                DATA_W      = 32,
   parameter int                NUM_REGS    = 32,
   parameter int                ADDR_W      = 5,
   parameter int                SP_REG      = 29,
   parameter int                RA_REG      = 31,
   parameter int                STACK_DEPTH = 16,
   parameter logic [DATA_W-1:0] SP_BASE     = DATA_W'(32'h00000055)
) (
   input  logic                         Clock,
   input  logic                         Reset,
   input  logic [ADDR_W-1:0]            ReadReg1,
   input  logic [ADDR_W-1:0]            ReadReg2,
   input  logic [ADDR_W-1:0]            WriteReg,
   input  logic [DATA_W-1:0]            WriteData,
   input  logic                         RegWrite,
   input  logic                         PC_Store,
   input  logic [DATA_W-1:0]            PC_Value,
   input  logic                         Push,
   input  logic                         Pull,
   input  logic [DATA_W-1:0]            PushData,
   output logic [DATA_W-1:0]            ReadData1,
   output logic [DATA_W-1:0]            ReadData2,
   output logic [DATA_W-1:0]            StackTop,
   output logic                         StackFull,
   output logic                         StackEmpty,
   output logic [$clog2(STACK_DEPTH):0] StackCount,
   output logic                         StackErr
);

   localparam int                IDX_W    = $clog2(STACK_DEPTH);
   localparam int                CNT_W    = IDX_W + 1;
   localparam logic [DATA_W-1:0] SP_EMPTY = SP_BASE - DATA_W'(1);
   localparam logic [ADDR_W-1:0] SP_IDX   = ADDR_W'(SP_REG);
   localparam logic [ADDR_W-1:0] RA_IDX   = ADDR_W'(RA_REG);

   logic [DATA_W-1:0] r_regs  [NUM_REGS];
   logic [DATA_W-1:0] r_stack [STACK_DEPTH];
   logic              r_err;

   logic [DATA_W-1:0] w_sp;
   logic [CNT_W-1:0]  w_count;
   logic [IDX_W-1:0]  w_topIdx;
   logic [IDX_W-1:0]  w_pushIdx;
   logic              w_full;
   logic              w_empty;
   logic              w_doPush;
   logic              w_doPull;
   logic              w_stackErr;
   logic              w_regWriteOk;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;

   // Occupancy falls out of the SP offset; the next free slot is the current count mod depth.
   assign w_sp         = r_regs[SP_REG];
   assign w_count      = CNT_W'(w_sp - SP_EMPTY);
   assign w_topIdx     = IDX_W'(w_sp - SP_BASE);
   assign w_pushIdx    = IDX_W'(w_count);
   assign w_full       = (w_count == CNT_W'(STACK_DEPTH));
   assign w_empty      = (w_count == '0);
   assign w_doPush     = Push && !Pull && !w_full;
   assign w_doPull     = Pull && !Push && !w_empty;
   assign w_stackErr   = (Push && Pull) || (Push && w_full) || (Pull && w_empty);
   assign w_regWriteOk = RegWrite && (WriteReg != '0) && (WriteReg != SP_IDX);

   // Architectural state; PC_Store is written after RegWrite so it wins on RA_REG.
   always_ff @(negedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= (i == SP_REG) ? SP_EMPTY : '0;
         end
         r_err <= 1'b0;
      end else begin
         if (w_regWriteOk) r_regs[WriteReg] <= WriteData;
         if (PC_Store)     r_regs[RA_REG]   <= PC_Value;
         if (w_doPush)      r_regs[SP_REG] <= w_sp + 1'b1;
         else if (w_doPull) r_regs[SP_REG] <= w_sp - 1'b1;
         if (w_stackErr) r_err <= 1'b1;
      end
   end

   // Stack contents survive reset; only the pointer is reinitialised.
   always_ff @(negedge Clock) begin
      if (!Reset && w_doPush) r_stack[w_pushIdx] <= PushData;
   end

   always_comb begin
      w_rd1 = (ReadReg1 == '0) ? '0 : r_regs[ReadReg1];
      w_rd2 = (ReadReg2 == '0) ? '0 : r_regs[ReadReg2];
`ifdef REGFILE_BYPASS_EN
      if (PC_Store && ReadReg1 == RA_IDX)              w_rd1 = PC_Value;
      else if (w_regWriteOk && ReadReg1 == WriteReg)   w_rd1 = WriteData;
      if (PC_Store && ReadReg2 == RA_IDX)              w_rd2 = PC_Value;
      else if (w_regWriteOk && ReadReg2 == WriteReg)   w_rd2 = WriteData;
`endif
      if (Push || Pull) w_rd2 = w_sp;
   end

   assign ReadData1  = w_rd1;
   assign ReadData2  = w_rd2;
   assign StackTop   = w_empty ? '0 : r_stack[w_topIdx];
   assign StackFull  = w_full;
   assign StackEmpty = w_empty;
   assign StackCount = w_count;
   assign StackErr   = r_err;

endmodule

// File: tb/tb_regfile_stack_param.sv
// Directed and random checks of regfile_stack_param against a queue-based reference model.
module tb_regfile_stack_param;

   logic        Clock = 1'b0;
   logic        Reset, RegWrite, PC_Store, Push, Pull;
   logic [4:0]  ReadReg1, ReadReg2, WriteReg;
   logic [31:0] WriteData, PC_Value, PushData;
   logic [31:0] ReadData1, ReadData2, StackTop;
   logic        StackFull, StackEmpty, StackErr;
   logic [4:0]  StackCount;

   int numChecks = 0;
   int numFails  = 0;

   // Reference model: plain register array plus a queue whose size is the stack occupancy.
   logic [31:0] mRegs [32];
   logic [31:0] mStack [$];
   bit          mErr;

   regfile_stack_param dut (
      .Clock(Clock), .Reset(Reset),
      .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
      .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
      .PC_Store(PC_Store), .PC_Value(PC_Value),
      .Push(Push), .Pull(Pull), .PushData(PushData),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .StackTop(StackTop),
      .StackFull(StackFull), .StackEmpty(StackEmpty),
      .StackCount(StackCount), .StackErr(StackErr)
   );

   always #5 Clock = ~Clock;

   function automatic logic [31:0] modelSp();
      return 32'h54 + 32'(mStack.size());
   endfunction

   function automatic logic [31:0] modelRead(input logic [4:0] idx);
      if (idx == 5'd0)  return 32'h0;
      if (idx == 5'd29) return modelSp();
      return mRegs[idx];
   endfunction

   function automatic logic [31:0] modelPort(input logic [4:0] idx);
      logic [31:0] v;
      v = modelRead(idx);
`ifdef REGFILE_BYPASS_EN
      if (PC_Store && idx == 5'd31) v = PC_Value;
      else if (RegWrite && WriteReg == idx && idx != 5'd0 && idx != 5'd29) v = WriteData;
`endif
      return v;
   endfunction

   task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      numChecks++;
      assert (observed === expected)
      else begin
         numFails++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [31:0] expRd2;
      logic [31:0] expTop;
      int          cnt;
      cnt    = mStack.size();
      expRd2 = (Push || Pull) ? modelSp() : modelPort(ReadReg2);
      expTop = (cnt == 0) ? 32'h0 : mStack[cnt-1];
      checkValue({tag, ".rd1"},   ReadData1, modelPort(ReadReg1));
      checkValue({tag, ".rd2"},   ReadData2, expRd2);
      checkValue({tag, ".top"},   StackTop, expTop);
      checkValue({tag, ".full"},  32'(StackFull), 32'(cnt == 16));
      checkValue({tag, ".empty"}, 32'(StackEmpty), 32'(cnt == 0));
      checkValue({tag, ".count"}, 32'(StackCount), 32'(cnt));
      checkValue({tag, ".err"},   32'(StackErr), 32'(mErr));
   endtask

   task automatic applyStimulus(input logic rst, input logic rw, input logic [4:0] wr,
                                input logic [31:0] wd, input logic pcs, input logic [31:0] pcv,
                                input logic psh, input logic pll, input logic [31:0] pd,
                                input logic [4:0] r1, input logic [4:0] r2);
      Reset = rst; RegWrite = rw; WriteReg = wr; WriteData = wd;
      PC_Store = pcs; PC_Value = pcv; Push = psh; Pull = pll; PushData = pd;
      ReadReg1 = r1; ReadReg2 = r2;
   endtask

   task automatic updateModel();
      if (Reset) begin
         foreach (mRegs[i]) mRegs[i] = 32'h0;
         mStack.delete();
         mErr = 1'b0;
      end else begin
         if (RegWrite && WriteReg != 5'd0 && WriteReg != 5'd29) mRegs[WriteReg] = WriteData;
         if (PC_Store) mRegs[31] = PC_Value;
         if (Push && Pull) mErr = 1'b1;
         else if (Push) begin
            if (mStack.size() == 16) mErr = 1'b1;
            else mStack.push_back(PushData);
         end else if (Pull) begin
            if (mStack.size() == 0) mErr = 1'b1;
            else void'(mStack.pop_back());
         end
      end
   endtask

   // One clock period: drive after the rising edge, check before the falling edge.
   task automatic runStep(input logic rst, input logic rw, input logic [4:0] wr,
                          input logic [31:0] wd, input logic pcs, input logic [31:0] pcv,
                          input logic psh, input logic pll, input logic [31:0] pd,
                          input logic [4:0] r1, input logic [4:0] r2,
                          input bit doCheck, input string tag);
      @(posedge Clock);
      #1;
      applyStimulus(rst, rw, wr, wd, pcs, pcv, psh, pll, pd, r1, r2);
      #2;
      if (doCheck) checkOutput(tag);
      updateModel();
      @(negedge Clock);
   endtask

   task automatic idleRead(input logic [4:0] r1, input logic [4:0] r2, input string tag);
      runStep(0, 0, 0, 0, 0, 0, 0, 0, 0, r1, r2, 1, tag);
   endtask

   initial begin
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      mErr = 1'b0;
      runStep(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "init");

      for (int i = 0; i < 32; i++) idleRead(5'(i), 5'(31 - i), "reset_read");

      runStep(0, 1, 5'd5,  32'hDEADBEEF, 0, 0, 0, 0, 0, 5'd5, 5'd0, 1, "wr_r5");
      runStep(0, 1, 5'd0,  32'h00001234, 0, 0, 0, 0, 0, 5'd0, 5'd5, 1, "wr_r0");
      runStep(0, 1, 5'd29, 32'h00000099, 0, 0, 0, 0, 0, 5'd29, 5'd0, 1, "wr_sp");
      idleRead(5'd5, 5'd29, "after_writes");
      idleRead(5'd0, 5'd29, "after_writes2");

      runStep(0, 0, 0, 0, 0, 0, 1, 0, 32'hA, 5'd29, 5'd3, 1, "push_a");
      runStep(0, 0, 0, 0, 0, 0, 1, 0, 32'hB, 5'd29, 5'd3, 1, "push_b");
      runStep(0, 0, 0, 0, 0, 0, 1, 0, 32'hC, 5'd29, 5'd3, 1, "push_c");
      idleRead(5'd29, 5'd29, "after_push");
      runStep(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd29, 5'd3, 1, "pull_1");
      runStep(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd29, 5'd3, 1, "pull_2");
      idleRead(5'd29, 5'd29, "after_pull");

      runStep(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset_fill");
      for (int i = 0; i < 17; i++) runStep(0, 0, 0, 0, 0, 0, 1, 0, $urandom, 5'd29, 5'd1, 1, "fill");
      idleRead(5'd29, 5'd29, "full");
      for (int i = 0; i < 17; i++) runStep(0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd29, 5'd1, 1, "drain");
      idleRead(5'd29, 5'd29, "empty");

      runStep(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset_pc");
      runStep(0, 1, 5'd31, 32'h55, 1, 32'h400, 0, 0, 0, 5'd31, 5'd31, 1, "pc_vs_rw");
      idleRead(5'd31, 5'd29, "pc_result");
      runStep(0, 0, 0, 0, 0, 0, 1, 1, 32'h77, 5'd29, 5'd29, 1, "push_pull");
      idleRead(5'd29, 5'd0, "push_pull_after");

      runStep(0, 1, 5'd7, 32'h77, 0, 0, 0, 0, 0, 5'd7, 5'd7, 1, "bypass_r7");
      idleRead(5'd7, 5'd7, "r7_after");
      runStep(0, 1, 5'd7, 32'h88, 1, 32'h500, 0, 0, 0, 5'd7, 5'd31, 1, "bypass_pc");
      idleRead(5'd7, 5'd31, "bypass_pc_after");
      runStep(1, 1, 5'd9, 32'h99, 1, 32'h600, 1, 0, 32'h1, 5'd9, 5'd31, 1, "reset_wins");
      idleRead(5'd9, 5'd31, "reset_wins_after");

      for (int i = 0; i < 600; i++) begin
         runStep(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, 5'($urandom),
                 $urandom, ($urandom_range(0, 7) == 0), $urandom,
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), $urandom,
                 5'($urandom), 5'($urandom), 1, "random");
      end
      idleRead(5'd29, 5'd31, "final");

      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/regfile_stack_param.md
Name: regfile_stack_param

Overview:
Parametrised general-purpose register file for the pipelined MIPS core, with an integrated hardware call stack.
- Width, register count, stack-pointer index, return-address index and stack depth are set by parameters.
- The stack-pointer register is owned by push/pull logic. It adds full/empty flags, an occupancy count and a sticky error flag for overflow, underflow and conflicting requests.
- Sits in the ID stage: reads are combinational, and writes land on the falling edge so the same cycle's ID read sees WB data.

Parameters:
DATA_W, 32, data width of every register and stack entry
NUM_REGS, 32, number of architectural registers (power of two)
ADDR_W, 5, register index width, log2(NUM_REGS)
SP_REG, 29, index of stack-pointer register
RA_REG, 31, index of return-address register
STACK_DEPTH, 16, number of stack entries (power of two, >=2)
SP_BASE, 32'h00000055, address of first stack entry; empty SP = SP_BASE-1

Ports:
Clock  input  1  core clock; all state updates on falling edge
Reset  input  1  synchronous, active-high reset
ReadReg1  input  ADDR_W  read port 1 index
ReadReg2  input  ADDR_W  read port 2 index
WriteReg  input  ADDR_W  write index
WriteData  input  DATA_W  write data
RegWrite  input  1  write enable
PC_Store  input  1  load PC_Value into RA_REG
PC_Value  input  DATA_W  return address
Push  input  1  push PushData
Pull  input  1  pop top entry
PushData  input  DATA_W  data to push
ReadData1  output  DATA_W  register[ReadReg1]
ReadData2  output  DATA_W  register[ReadReg2], or SP when Push|Pull
StackTop  output  DATA_W  entry at SP (0 when empty)
StackFull  output  1  count == STACK_DEPTH
StackEmpty  output  1  count == 0
StackCount  output  log2(STACK_DEPTH)+1  occupancy
StackErr  output  1  sticky error flag

Behaviour:
Clock, reset and write rules
- Clock and reset: one clock; Reset is synchronous and active-high. All sequential updates occur on the falling edge of Clock.
- Reset (sampled on the falling edge):
  - All registers clear to 0, except SP_REG, which loads SP_BASE-1 directly; there is no post-reset init cycle.
  - Stack contents are unchanged.
  - StackErr=0.
- Outputs after reset: ReadData1/2 = 0 for all indices except SP_REG (0x54 by default). StackEmpty=1, StackFull=0, StackCount=0, StackTop=0.
- Register 0: always reads 0; writes are discarded.
- RegWrite: writes WriteData to register[WriteReg] on the falling edge.
  - A RegWrite to SP_REG is ignored; SP is owned by the stack logic.
- PC_Store: writes PC_Value to RA_REG. If RegWrite targets RA_REG in the same cycle, PC_Store wins.

Read ports
- Reads are combinational from stored state.
- ReadData2 is forced to the current SP while Push or Pull is high, giving the RAM address path.

Stack operations
- Push only, not full: SP <= SP+1; entry[SP+1-SP_BASE] <= PushData.
- Pull only, not empty: SP <= SP-1. The popped value is StackTop, valid during the Pull cycle.
- Push while full: no state change, StackErr <= 1.
- Pull while empty: no state change, StackErr <= 1.
- Push and Pull together: no stack change, StackErr <= 1.
- StackErr stays set until Reset.

Derived outputs and index arithmetic
- StackCount = SP - (SP_BASE-1), truncated.
- StackFull and StackEmpty are combinational from StackCount.
- Stack index arithmetic is modulo STACK_DEPTH; SP itself is full DATA_W and never wraps, because the full/empty guards block it.

Timing
- Latency: write-to-read is 0 cycles within the same clock period, since the write lands on the falling edge before the next rising-edge consumer.
- Push/pull take effect in 1 cycle.

Reset mid-operation
- Reset asserted with Push/Pull/RegWrite: reset wins and all other requests that cycle are dropped.

Optional Feature:
Macro: REGFILE_BYPASS_EN
- Defined: combinational write-through. If RegWrite && WriteReg!=0 && WriteReg!=SP_REG && WriteReg==ReadRegN, ReadDataN returns WriteData in the same cycle.
  - Likewise, PC_Store forwards PC_Value for reads of RA_REG.
  - The Push/Pull override of ReadData2 still takes priority.
- Undefined: reads return stored state only.

Test Plan:
1. Reset; read all 32 indices -> all 0 except r29=0x00000054; StackEmpty=1, StackCount=0, StackErr=0.
2. RegWrite r5=0xDEADBEEF, then r0=0x1234, then r29=0x99 -> r5 reads 0xDEADBEEF; r0 reads 0; r29 still 0x54.
3. Push 0xA, 0xB, 0xC on consecutive cycles -> SP=0x57, StackCount=3, StackTop=0xC. While Push is high, ReadData2 shows SP (0x54, 0x55, 0x56 per cycle). Pull twice -> StackTop=0xA, SP=0x55.
4. Push 16 entries, then one more Push -> StackFull=1, SP=0x64, the 17th push is ignored and StackErr=1. Pull 16 -> StackEmpty=1. Pull again -> SP stays 0x54 and StackErr stays 1 until Reset.
5. Same cycle: PC_Store with PC_Value=0x400 and RegWrite r31=0x55 -> r31=0x400. Push and Pull together -> SP unchanged, StackErr=1.
6. With REGFILE_BYPASS_EN: RegWrite r7=0x77, ReadReg1=7 in the same cycle before the falling edge -> ReadData1=0x77. Without the macro -> old value until the falling edge.
